// File: rtl/rename_pkg.sv
// Shared rename-stage definitions: register-file geometry, preg type and free-list FSM states.
package rename_pkg;

    localparam int NUM_PHYS_REGS = 64;
    localparam int NUM_ARCH_REGS = 32;
    localparam int PREG_W        = $clog2(NUM_PHYS_REGS);

    typedef logic [PREG_W-1:0] preg_t;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fl_state_e;

endpackage

// File: rtl/preg_freelist_ram.sv
// Free-list storage: one synchronous write port, one asynchronous read port, no reset on contents.
module freelist_ram #(
    parameter int DEPTH  = 32,
    parameter int DATA_W = 6,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/preg_freelist.sv
// Physical-register free list: circular FIFO of free pregs with a speculative alloc head,
// an architectural (retire) head restored on flush, and a tail fed by ROB releases.
module preg_freelist #(
    parameter int NUM_PHYS_REGS = rename_pkg::NUM_PHYS_REGS,
    parameter int NUM_ARCH_REGS = rename_pkg::NUM_ARCH_REGS,
    parameter int PREG_W        = rename_pkg::PREG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rn2fl_req,
    output logic              fl2rn_grant,
    output logic [PREG_W-1:0] fl2rn_preg,
    input  logic              rob2fl_commit,
    input  logic              rob2fl_free_valid,
    input  logic [PREG_W-1:0] rob2fl_free_preg,
    input  logic              rob2fl_flush,
    output logic              fl_ready,
    output logic              no_free_reg,
    output logic [PREG_W-1:0] fl_count
);
    import rename_pkg::*;

    localparam int DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;

    fl_state_e         state, state_nxt;
    ptr_t              spec_head, spec_head_nxt;
    ptr_t              ret_head, ret_head_nxt;
    ptr_t              tail, tail_nxt;
    logic [IDX_W-1:0]  fill, fill_nxt;

    ptr_t              spec_cnt;
    ptr_t              ret_span;
    logic              active;
    logic              full;
    logic              do_commit;
    logic              do_free;
    logic              grant;

    logic              wr_en;
    logic [IDX_W-1:0]  wr_addr;
    logic [PREG_W-1:0] wr_data;
    logic [PREG_W-1:0] rd_data;

    // Wrap-bit pointers: differences modulo 2*DEPTH give occupancy 0..DEPTH unambiguously.
    assign spec_cnt  = tail - spec_head;
    assign ret_span  = tail - ret_head;
    assign full      = (ret_span == ptr_t'(DEPTH));
    assign active    = (state != INIT);

    assign grant     = (state == RUN) & rn2fl_req & (spec_cnt != '0) & ~rob2fl_flush;
    assign do_commit = active & rob2fl_commit & (ret_head != spec_head);
    assign do_free   = active & rob2fl_free_valid & (rob2fl_free_preg != '0) & ~full;

    always_comb begin
        state_nxt     = state;
        spec_head_nxt = spec_head;
        ret_head_nxt  = ret_head;
        tail_nxt      = tail;
        fill_nxt      = fill;
        wr_en         = 1'b0;
        wr_addr       = tail[IDX_W-1:0];
        wr_data       = rob2fl_free_preg;

        case (state)
            INIT: begin
                wr_en    = 1'b1;
                wr_addr  = fill;
                wr_data  = PREG_W'(NUM_ARCH_REGS) + PREG_W'(fill);
                fill_nxt = fill + 1'b1;
                if (fill == IDX_W'(DEPTH - 1)) begin
                    spec_head_nxt = '0;
                    ret_head_nxt  = '0;
                    tail_nxt      = ptr_t'(DEPTH);
                    state_nxt     = RUN;
                end
            end

            RUN, FLUSH: begin
                if (grant) begin
                    spec_head_nxt = spec_head + 1'b1;
                end
                if (do_commit) begin
                    ret_head_nxt = ret_head + 1'b1;
                end
                if (do_free) begin
                    wr_en    = 1'b1;
                    tail_nxt = tail + 1'b1;
                end
                // Recovery rewinds to the retire head including this cycle's commit.
                if (state == FLUSH) begin
                    spec_head_nxt = ret_head_nxt;
                    state_nxt     = RUN;
                end else if (rob2fl_flush) begin
                    spec_head_nxt = ret_head_nxt;
                    state_nxt     = FLUSH;
                end
            end

            default: begin
                state_nxt = INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            fill      <= '0;
            spec_head <= '0;
            ret_head  <= '0;
            tail      <= '0;
        end else begin
            state     <= state_nxt;
            fill      <= fill_nxt;
            spec_head <= spec_head_nxt;
            ret_head  <= ret_head_nxt;
            tail      <= tail_nxt;
        end
    end

    freelist_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (PREG_W),
        .ADDR_W (IDX_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en & ~rst),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (spec_head[IDX_W-1:0]),
        .rd_data (rd_data)
    );

    assign fl2rn_grant = grant;
    assign fl2rn_preg  = grant ? rd_data : '0;
    assign fl_ready    = active;
    assign no_free_reg = (spec_cnt == '0);
    assign fl_count    = PREG_W'(spec_cnt);

endmodule

// File: tb/tb_preg_freelist.sv
// Directed bench for preg_freelist: init fill, drain, free-to-empty, flush recovery,
// dropped frees and mid-run reset, each checked against hand-computed values.
module tb_preg_freelist;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic       grant;
    logic [5:0] preg;
    logic       commit;
    logic       free_valid;
    logic [5:0] free_preg;
    logic       flush;
    logic       ready;
    logic       nfr;
    logic [5:0] count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    preg_freelist dut (
        .clk               (clk),
        .rst               (rst),
        .rn2fl_req         (req),
        .fl2rn_grant       (grant),
        .fl2rn_preg        (preg),
        .rob2fl_commit     (commit),
        .rob2fl_free_valid (free_valid),
        .rob2fl_free_preg  (free_preg),
        .rob2fl_flush      (flush),
        .fl_ready          (ready),
        .no_free_reg       (nfr),
        .fl_count          (count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle();
        req        = 1'b0;
        commit     = 1'b0;
        free_valid = 1'b0;
        free_preg  = 6'd0;
        flush      = 1'b0;
    endtask

    // Reset, check reset outputs, then walk the 32-cycle fill with req held high.
    task automatic reset_and_init(input bit watch);
        idle();
        req = 1'b1;
        rst = 1'b1;
        cyc();
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_preg",  32'(preg),  32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_nfr",   32'(nfr),   32'd1);
        chk("rst_count", 32'(count), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 32; k++) begin
            #1;
            if (watch) chk("init_grant", 32'(grant), 32'd0);
            cyc();
        end
        #1;
        chk("init_ready", 32'(ready), 32'd1);
        chk("init_count", 32'(count), 32'd32);
        req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        idle();
        rst = 1'b1;

        // Init fill, then drain all 32 entries in order.
        reset_and_init(1'b1);
        req = 1'b1;
        for (int k = 0; k < 32; k++) begin
            #1;
            chk("drain_grant", 32'(grant), 32'd1);
            chk("drain_preg",  32'(preg),  32'(32 + k));
            cyc();
        end
        #1;
        chk("empty_grant", 32'(grant), 32'd0);
        chk("empty_nfr",   32'(nfr),   32'd1);
        chk("empty_count", 32'(count), 32'd0);

        // Free into an empty list with a same-cycle request: no bypass.
        req    = 1'b0;
        commit = 1'b1;
        cyc();
        commit     = 1'b0;
        req        = 1'b1;
        free_valid = 1'b1;
        free_preg  = 6'd5;
        #1;
        chk("nobypass_grant", 32'(grant), 32'd0);
        cyc();
        free_valid = 1'b0;
        #1;
        chk("freed_count", 32'(count), 32'd1);
        chk("freed_grant", 32'(grant), 32'd1);
        chk("freed_preg",  32'(preg),  32'd5);
        cyc();
        req = 1'b0;
        #1;
        chk("refill_empty_nfr", 32'(nfr), 32'd1);

        // Alloc 4, commit 2, flush: recovery resumes at preg 34.
        reset_and_init(1'b0);
        req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("f1_alloc_preg", 32'(preg), 32'(32 + k));
            cyc();
        end
        req    = 1'b0;
        commit = 1'b1;
        cyc();
        cyc();
        commit = 1'b0;
        flush  = 1'b1;
        req    = 1'b1;
        #1;
        chk("f1_flush_edge_grant", 32'(grant), 32'd0);
        cyc();
        flush = 1'b0;
        #1;
        chk("f1_flush_state_grant", 32'(grant), 32'd0);
        chk("f1_flush_count",       32'(count), 32'd30);
        cyc();
        #1;
        chk("f1_resume_grant", 32'(grant), 32'd1);
        chk("f1_resume_preg",  32'(preg),  32'd34);
        req = 1'b0;

        // Flush with a same-cycle commit after 3 allocs and 1 earlier commit.
        reset_and_init(1'b0);
        req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("f2_alloc_preg", 32'(preg), 32'(32 + k));
            cyc();
        end
        req    = 1'b0;
        commit = 1'b1;
        cyc();
        flush = 1'b1;
        cyc();
        commit = 1'b0;
        flush  = 1'b0;
        req    = 1'b1;
        #1;
        chk("f2_flush_state_grant", 32'(grant), 32'd0);
        chk("f2_flush_count",       32'(count), 32'd30);
        cyc();
        #1;
        chk("f2_resume_preg", 32'(preg), 32'd34);
        req = 1'b0;

        // A free of preg 0 is dropped; a real free advances the tail.
        reset_and_init(1'b0);
        req = 1'b1;
        cyc();
        cyc();
        req    = 1'b0;
        commit = 1'b1;
        cyc();
        cyc();
        commit = 1'b0;
        #1;
        chk("p0_count_before", 32'(count), 32'd30);
        free_valid = 1'b1;
        free_preg  = 6'd0;
        cyc();
        free_valid = 1'b0;
        #1;
        chk("p0_count_after", 32'(count), 32'd30);
        free_valid = 1'b1;
        free_preg  = 6'd7;
        cyc();
        free_valid = 1'b0;
        #1;
        chk("p7_count_after", 32'(count), 32'd31);

        // Free while full: flagged as full beforehand, write dropped, storage intact.
        reset_and_init(1'b0);
        chk("full_before_free", 32'(count == 6'd32), 32'd1);
        free_valid = 1'b1;
        free_preg  = 6'd9;
        cyc();
        free_valid = 1'b0;
        req        = 1'b1;
        #1;
        chk("full_free_count", 32'(count), 32'd32);
        chk("full_free_preg",  32'(preg),  32'd32);
        cyc();
        req = 1'b0;

        // Mid-run reset with 10 allocated: back to reset values and a fresh fill.
        reset_and_init(1'b0);
        req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("mr_alloc_preg", 32'(preg), 32'(32 + k));
            cyc();
        end
        #1;
        chk("mr_count_before", 32'(count), 32'd22);
        reset_and_init(1'b1);
        req = 1'b1;
        #1;
        chk("mr_first_grant", 32'(grant), 32'd1);
        chk("mr_first_preg",  32'(preg),  32'd32);
        cyc();
        idle();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/preg_freelist.md
# preg_freelist

Physical-register free-list controller for the rename stage. Holds unallocated physical register numbers in a circular FIFO. It hands one per cycle to the rename unit, accepts released registers from ROB commit, and restores the speculative allocation pointer on a pipeline flush. It replaces the bit-vector scan in rename with a pointer-based allocator that supports commit and recovery.

## Interface
- `NUM_PHYS_REGS`, 64, physical register count
- `NUM_ARCH_REGS`, 32, architectural register count; physical regs 0..NUM_ARCH_REGS-1 are mapped at reset
- `PREG_W`, 6, physical register index width
- `clk` in 1: single clock; all state updates on rising edge
- `rst` in 1: synchronous, active-high reset
- `rn2fl_req` in 1: rename needs a destination preg this cycle
- `fl2rn_grant` out 1: allocation accepted this cycle
- `fl2rn_preg` out PREG_W: allocated preg; valid when `fl2rn_grant`
- `rob2fl_commit` in 1: ROB retires one rd-writing instruction; advances the retire head
- `rob2fl_free_valid` in 1: old preg of a retired instruction is released
- `rob2fl_free_preg` in PREG_W: preg being released
- `rob2fl_flush` in 1: squash all speculative allocations
- `fl_ready` out 1: initialisation done, allocator usable
- `no_free_reg` out 1: speculative count is zero
- `fl_count` out PREG_W: number of speculatively free entries (0..DEPTH)

## Operation
- DEPTH = NUM_PHYS_REGS − NUM_ARCH_REGS (32). Storage: DEPTH×PREG_W entries.
- Pointers are log2(DEPTH)+1 bits wide, with the MSB as the wrap bit:
  - `spec_head`: next alloc.
  - `ret_head`: architectural head.
  - `tail`: next free write.
- Counts use modulo 2·DEPTH pointer arithmetic:
  - spec count = tail − spec_head.
  - full when tail − ret_head == DEPTH.
- FSM states: INIT, RUN, FLUSH.
  - **INIT**, entered on `rst`:
    - A 5-bit fill counter i writes mem[i] = NUM_ARCH_REGS + i, one entry per cycle, for DEPTH cycles.
    - On the last write: spec_head = ret_head = 0, tail = DEPTH (wrap bit 1, index 0), go to RUN.
    - Inputs are ignored; grant is 0.
  - **RUN**:
    - Alloc: grant = rn2fl_req & (spec count ≠ 0) & ~rob2fl_flush. preg = mem[spec_head]. spec_head++ on grant.
    - Commit: ret_head++ on rob2fl_commit.
    - Free: if rob2fl_free_valid and rob2fl_free_preg ≠ 0, write mem[tail] and tail++. A free of preg 0 is dropped.
  - **FLUSH**, entered from RUN when `rob2fl_flush`:
    - On that edge, spec_head ← ret_head, after applying any same-cycle commit increment.
    - Stays one cycle with grant = 0, then returns to RUN.
    - Commit and free continue to be processed in FLUSH.
- Simultaneous alloc + free with spec count 0: no bypass. Grant is 0; the freed entry is allocatable next cycle.
- Simultaneous alloc + free with count > 0: both occur; count unchanged.
- Free while full is a protocol violation. The write is dropped; the bench flags it with an assertion.
- Commit with ret_head == spec_head is a protocol violation; it is ignored.
- `rst` asserted mid-operation discards all state and restarts INIT.

## Timing
- Reset values:
  - fl2rn_grant = 0, fl2rn_preg = 0.
  - fl_ready = 0, no_free_reg = 1, fl_count = 0.
  - State = INIT.
- fl_ready rises DEPTH cycles after rst deasserts (cycle 32). fl_count = 32 in that same cycle.
- fl2rn_grant and fl2rn_preg are combinational from registered state and same-cycle inputs (zero latency). The pointer update is visible next cycle.
- fl_count and no_free_reg derive from registered pointers only; they reflect updates one cycle after the event.
- Flush recovery takes 2 cycles: the flush edge, then the FLUSH state. The first grant is possible in the cycle after FLUSH.

## Structure
- Shared package `rename_pkg`: NUM_PHYS_REGS, NUM_ARCH_REGS, PREG_W, `preg_t` typedef, `fl_state_e` enum {INIT, RUN, FLUSH}. The rename unit and ROB import the same package.
- One sub-module, `freelist_ram`:
  - DEPTH×PREG_W, 1 write port, 1 asynchronous read port.
  - Pointer and FSM logic stays in preg_freelist.

## Test plan
- Reset, hold rn2fl_req=1 → grant=0 for 32 cycles. Cycle 32: fl_ready=1, first grant returns preg 32, then 33, 34… through 63. After 32 grants, no_free_reg=1, grant=0.
- Drain to empty, then free preg 5 with req=1 in the same cycle → grant=0. Next cycle, grant=1 with preg 5.
- Alloc 4 (32..35), commit 2, flush → FLUSH cycle has grant=0. Next alloc returns preg 34. fl_count=30.
- Flush with a simultaneous commit after 3 allocs and 1 prior commit → spec_head lands 2 past the start. Next alloc returns preg 34.
- Free preg 0 → tail unchanged, fl_count unchanged. Free while full → assertion fires, fl_count stays 32.
- Assert rst mid-RUN with 10 regs allocated → outputs return to reset values next cycle. INIT repeats and the first grant is preg 32 again.
